// File: rtl/rb_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: default widths and grant encoding.
// Optional feature macro used by the top: ZERO_REG_EN (address 0 is a discard target).
package rb_write_arbiter_pkg;
    localparam int RB_DW   = 32;
    localparam int RB_AW   = 5;
    localparam int RB_NREG = 1 << RB_AW;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;
endpackage

// File: rtl/rb_write_arbiter_wr_fifo.sv
// Per-requester write FIFO; exposes per-entry valid/address so the top can build the pending mask.
module rb_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    output logic                      full,
    output logic                      empty,
    output logic [AW-1:0]             head_addr,
    output logic [DW-1:0]             head_data,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][AW-1:0] mem_addr;
    logic [DEPTH-1:0][DW-1:0] mem_data;
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [PW:0]              count;
    logic                     do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Fullness is judged before the edge, so a same-cycle pop never makes room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign ent_addr  = mem_addr;

    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end
endmodule

// File: rtl/rb_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between ALU (A) and load (B) writeback.
// Optional macro ZERO_REG_EN: writes to address 0 are drained but never committed.
module rb_write_arbiter
    import rb_write_arbiter_pkg::*;
#(
    parameter int DW    = RB_DW,
    parameter int AW    = RB_AW,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_data,
    output logic             RW,
    output logic [AW-1:0]    wR,
    output logic [DW-1:0]    wD,
    output logic [2**AW-1:0] pending,
    output logic             busy
);
    logic                     a_full, a_empty, b_full, b_empty;
    logic [AW-1:0]            a_haddr, b_haddr, sel_addr;
    logic [DW-1:0]            a_hdata, b_hdata, sel_data;
    logic [DEPTH-1:0]         a_ent_valid, b_ent_valid;
    logic [DEPTH-1:0][AW-1:0] a_ent_addr, b_ent_addr;
    logic                     gnt_a, gnt_b, commit;
    gnt_e                     last_grant, last_grant_next;

    rb_wr_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(a_valid), .pop(gnt_a),
        .in_addr(a_addr), .in_data(a_data), .full(a_full), .empty(a_empty),
        .head_addr(a_haddr), .head_data(a_hdata),
        .ent_valid(a_ent_valid), .ent_addr(a_ent_addr)
    );

    rb_wr_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(b_valid), .pop(gnt_b),
        .in_addr(b_addr), .in_data(b_data), .full(b_full), .empty(b_empty),
        .head_addr(b_haddr), .head_data(b_hdata),
        .ent_valid(b_ent_valid), .ent_addr(b_ent_addr)
    );

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= GNT_B;
        else        last_grant <= last_grant_next;
    end

    always_comb begin
        last_grant_next = last_grant;
        if (gnt_a)      last_grant_next = GNT_A;
        else if (gnt_b) last_grant_next = GNT_B;
    end

    // Contention goes to whichever side did not win last.
    always_comb begin
        gnt_a = !a_empty && (b_empty || last_grant == GNT_B);
        gnt_b = !b_empty && (a_empty || last_grant == GNT_A);
    end

    assign sel_addr = gnt_a ? a_haddr : b_haddr;
    assign sel_data = gnt_a ? a_hdata : b_hdata;

`ifdef ZERO_REG_EN
    assign commit = (gnt_a || gnt_b) && (sel_addr != '0);
`else
    assign commit = gnt_a || gnt_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RW <= 1'b0;
            wR <= '0;
            wD <= '0;
        end else begin
            RW <= commit;
            if (commit) begin
                wR <= sel_addr;
                wD <= sel_data;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ent_valid[i]) pending[a_ent_addr[i]] = 1'b1;
            if (b_ent_valid[i]) pending[b_ent_addr[i]] = 1'b1;
        end
        if (RW) pending[wR] = 1'b1;
`ifdef ZERO_REG_EN
        pending[0] = 1'b0;
`endif
    end

    assign busy = !a_empty || !b_empty || RW;
endmodule

// File: tb/tb_rb_write_arbiter.sv
// Directed + randomized bench for rb_write_arbiter against a queue-based reference model.
// Honors ZERO_REG_EN the same way the design does when built with that macro.
module tb_rb_write_arbiter;
    localparam int DEPTH = 2;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0, wR;
    logic [31:0] a_data = '0, b_data = '0, wD, pending;
    logic        RW, busy;

    always #5 clk = ~clk;

    rb_write_arbiter #(.DW(32), .AW(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .RW(RW), .wR(wR), .wD(wD), .pending(pending), .busy(busy)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

    ent_t        qa[$], qb[$], sa[$], sb[$];
    logic [4:0]  commits[$];
    int          commit_cyc[$];
    bit          m_rw, m_last;  // m_last: 0 = A won last, 1 = B won last
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [31:0] m_reg[32], dut_reg[32];
    int          compared = 0, mismatched = 0, cyc = 0;
    bit          saw_a_full = 0, rnd_gap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        qa.delete(); qb.delete();
        m_rw = 0; m_wr = '0; m_wd = '0; m_last = 1;
    endtask

    // One rising edge of the reference: grant from pre-edge occupancy, then accept pushes.
    task automatic m_step();
        int   na = qa.size(), nb = qb.size();
        bit   acc_a = a_valid && na < DEPTH, acc_b = b_valid && nb < DEPTH;
        bit   ga = na > 0 && (nb == 0 || m_last);
        bit   gb = nb > 0 && (na == 0 || !m_last);
        ent_t h, e;
        if (ga) begin h = qa.pop_front(); m_last = 0; end
        else if (gb) begin h = qb.pop_front(); m_last = 1; end
        if (ga || gb) begin
            m_rw = !(ZR && h.a == 0);
            if (m_rw) begin m_wr = h.a; m_wd = h.d; m_reg[h.a] = h.d; end
        end else m_rw = 0;
        if (acc_a) begin e.a = a_addr; e.d = a_data; qa.push_back(e); if (sa.size() > 0) void'(sa.pop_front()); end
        if (acc_b) begin e.a = b_addr; e.d = b_data; qb.push_back(e); if (sb.size() > 0) void'(sb.pop_front()); end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (qa[i]) p[qa[i].a] = 1'b1;
        foreach (qb[i]) p[qb[i].a] = 1'b1;
        if (m_rw) p[m_wr] = 1'b1;
        if (ZR) p[0] = 1'b0;
        return p;
    endfunction

    task automatic check_all();
        chk("rw", RW, m_rw);
        chk("wr", wR, m_wr);
        chk("wd", wD, m_wd);
        chk("pending", pending, exp_pending());
        chk("busy", busy, (qa.size() > 0 || qb.size() > 0 || m_rw));
        chk("a_ready", a_ready, qa.size() < DEPTH);
        chk("b_ready", b_ready, qb.size() < DEPTH);
    endtask

    task automatic drive();
        a_valid = sa.size() > 0 && !(rnd_gap && $urandom_range(0, 3) == 0);
        if (sa.size() > 0) begin a_addr = sa[0].a; a_data = sa[0].d; end
        b_valid = sb.size() > 0 && !(rnd_gap && $urandom_range(0, 3) == 0);
        if (sb.size() > 0) begin b_addr = sb[0].a; b_data = sb[0].d; end
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
        if (RW) begin dut_reg[wR] = wD; commits.push_back(wR); commit_cyc.push_back(cyc); end
        if (!a_ready) saw_a_full = 1;
        cyc++;
        check_all();
    endtask

    task automatic drain();
        int n = 0;
        while ((sa.size() > 0 || sb.size() > 0 || qa.size() > 0 || qb.size() > 0 || m_rw) && n < 200) begin
            cycle(); n++;
        end
        chk("drain_timeout", n < 200, 1);
        a_valid = 0; b_valid = 0;
    endtask

    // Reset asserted mid-cycle: outputs must drop without waiting for an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_rw", RW, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {a_ready, b_ready}, 2'b11);
        chk("rst_wr", wR, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic ent_t mk(input int a, input logic [31:0] d);
        ent_t e; e.a = 5'(a); e.d = d; return e;
    endfunction

    initial begin
        logic [4:0] exp3[6] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        logic [4:0] acom[$];
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; dut_reg[i] = '0; end
        m_reset();
        @(negedge clk);
        do_reset();

        // Single A write, uncontended.
        sa.push_back(mk(5, 32'hCAFE0001));
        cycle();
        chk("single_pend5", pending[5], 1);
        chk("single_rw_early", RW, 0);
        cycle();
        chk("single_rw", RW, 1);
        chk("single_wr", wR, 5);
        chk("single_wd", wD, 32'hCAFE0001);
        chk("single_pend5_out", pending[5], 1);
        cycle();
        chk("single_rw_drop", RW, 0);
        chk("single_pend5_clr", pending[5], 0);

        // Both requesters streaming; last_grant starts at B after reset.
        @(negedge clk);
        do_reset();
        commits.delete(); commit_cyc.delete(); saw_a_full = 0;
        for (int i = 0; i < 3; i++) begin
            sa.push_back(mk(1 + i, 32'h100 + i));
            sb.push_back(mk(9 + i, 32'h900 + i));
        end
        drain();
        chk("rr_count", commits.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), commits[i], exp3[i]);
        chk("rr_no_gap", commit_cyc[5] - commit_cyc[0], 5);
        chk("rr_a_filled", saw_a_full, 1);

        // A FIFO backpressure under contention; all A data must land in order.
        commits.delete(); saw_a_full = 0;
        for (int i = 0; i < 4; i++) begin
            sa.push_back(mk(12 + i, 32'hA000 + i));
            sb.push_back(mk(20 + i, 32'hB000 + i));
        end
        drain();
        chk("fill_saw_full", saw_a_full, 1);
        foreach (commits[i]) if (commits[i] >= 12 && commits[i] <= 15) acom.push_back(commits[i]);
        chk("fill_a_count", acom.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("fill_a_order%0d", i), acom[i], 12 + i);
        chk("fill_reg15", dut_reg[15], 32'hA003);

        // Same address from A then B: B's value must win.
        sa.push_back(mk(7, 32'd11));
        cycle();
        sb.push_back(mk(7, 32'd22));
        drain();
        chk("same_addr_reg7", dut_reg[7], 32'd22);

        // Address 0 write.
        sa.push_back(mk(0, 32'h0BAD0000));
        cycle();
        chk("zero_pend0", pending[0], ZR ? 1'b0 : 1'b1);
        cycle();
        chk("zero_rw", RW, !ZR);
        chk("zero_wr", wR, ZR ? 5'd7 : 5'd0);
        drain();

        // Randomized traffic with a reset dropped into the middle of it.
        rnd_gap = 1;
        for (int i = 0; i < 400; i++) begin
            if (sa.size() < 3 && $urandom_range(0, 1)) sa.push_back(mk($urandom_range(0, 31), $urandom));
            if (sb.size() < 3 && $urandom_range(0, 1)) sb.push_back(mk($urandom_range(0, 31), $urandom));
            if (i == 200) do_reset();
            else cycle();
        end
        rnd_gap = 0;
        drain();
        for (int i = 0; i < 32; i++) chk($sformatf("final_reg%0d", i), dut_reg[i], m_reg[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
